product_accumulator: RTL



---
 rtl/product_acc_pkg.sv | 9 +
 rtl/product_accumulator_if.sv | 24 ++
 rtl/acc_result_slot.sv | 27 ++
 rtl/product_accumulator.sv | 66 ++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// product_acc_pkg: shared state encoding and width defaults for the product accumulator
package product_acc_pkg;
   typedef enum logic {IDLE, ACCUM} state_t;
   localparam int PROD_W_DEF = 64;
   localparam int MAX_LEN_DEF = 256;
   function automatic int acc_width(input int prod_w, input int max_len);
      return prod_w + $clog2(max_len);
   endfunction
endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: vector control, product stream and result handshake bundle
interface product_accumulator_if
   import product_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int LEN_W = $clog2(MAX_LEN + 1),
   parameter int ACC_W = acc_width(PROD_W, MAX_LEN)
);
   logic start;
   logic [LEN_W-1:0] vec_len;
   logic [PROD_W-1:0] prod;
   logic prod_valid;
   logic busy;
   logic [ACC_W-1:0] result;
   logic result_valid;
   logic result_ready;
   logic overrun_err;
   logic stray_err;
   modport master(output start, vec_len, prod, prod_valid, result_ready,
                  input busy, result, result_valid, overrun_err, stray_err);
   modport slave(input start, vec_len, prod, prod_valid, result_ready,
                 output busy, result, result_valid, overrun_err, stray_err);
endinterface

// File: rtl/acc_result_slot.sv
// acc_result_slot: one-entry result register with valid/ready and sticky overrun detection
module acc_result_slot #(
   parameter int ACC_W = 72
) (
   input  logic clk,
   input  logic reset,
   input  logic wr,
   input  logic [ACC_W-1:0] wr_data,
   input  logic ready,
   output logic [ACC_W-1:0] data,
   output logic valid,
   output logic overrun
);
   always_ff @(posedge clk) begin
      if (reset) begin
         data <= '0;
         valid <= 1'b0;
         overrun <= 1'b0;
      end else if (wr) begin
         data <= wr_data;
         valid <= 1'b1;
         if (valid && !ready) overrun <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of multiplier products into one result
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int LEN_W = $clog2(MAX_LEN + 1),
   parameter int ACC_W = acc_width(PROD_W, MAX_LEN)
) (
   input logic clk,
   input logic reset,
   product_accumulator_if.slave bus
);
   state_t state, state_n;
   logic [LEN_W-1:0] len, len_n, count, count_n, len_clamp;
   logic [ACC_W-1:0] acc, acc_n, sum;
   logic last, zero_start, wr, stray;
   assign len_clamp = (bus.vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.vec_len;
   assign sum = acc + ACC_W'(bus.prod);
   assign last = count == len - LEN_W'(1);
   assign zero_start = state == IDLE && bus.start && bus.vec_len == '0;
   assign wr = zero_start || (state == ACCUM && bus.prod_valid && last);
   assign bus.busy = state == ACCUM;
   always_comb begin
      state_n = state;
      len_n = len;
      count_n = count;
      acc_n = acc;
      if (state == IDLE && bus.start && bus.vec_len != '0) begin
         state_n = ACCUM;
         len_n = len_clamp;
         count_n = '0;
         acc_n = '0;
      end else if (state == ACCUM && bus.prod_valid) begin
         state_n = last ? IDLE : ACCUM;
         count_n = count + LEN_W'(1);
         acc_n = sum;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         len <= '0;
         count <= '0;
         acc <= '0;
         stray <= 1'b0;
      end else begin
         state <= state_n;
         len <= len_n;
         count <= count_n;
         acc <= acc_n;
         if (state == IDLE && bus.prod_valid) stray <= 1'b1;
      end
   end
   assign bus.stray_err = stray;
   acc_result_slot #(.ACC_W(ACC_W)) slot (
      .clk(clk),
      .reset(reset),
      .wr(wr),
      .wr_data(zero_start ? '0 : sum),
      .ready(bus.result_ready),
      .data(bus.result),
      .valid(bus.result_valid),
      .overrun(bus.overrun_err)
   );
endmodule
